aes_out_serializer: RTL and testbench

Downstream stage of the AES cipher core: captures each completed 128-bit ciphertext block when the cipher's `done` rises and buffers up to DEPTH blocks. Blocks drain to the RISC-V core's data path as four 32-bit words under a valid/ready handshake. Decouples cipher completion from the consumer's read rate and flags dropped blocks.

---
 rtl/aes_out_serializer.sv | 128 ++++++++++++
 tb/tb_aes_out_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_serializer.sv
// aes_out_serializer
// Buffers up to DEPTH completed 128-bit AES ciphertext blocks and drains them
// as four 32-bit words (MSB word first) under a valid/ready handshake.
// A block that arrives while every slot is occupied is dropped and latched in
// the sticky ovf_o flag.
// Optional build macro: AES_OUT_BSWAP_EN byte-reverses each output word for a
// little-endian load path. Word order inside the block is not affected.

module aes_out_serializer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done_i,
    input  logic [127:0] text_i,
    output logic [31:0]  word_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         last_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         ovf_o,
    input  logic         clr_ovf_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [127:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_widx;
    logic             r_done_d;
    logic             r_ovf;

    logic             w_empty;
    logic             w_full;
    logic             w_capture;
    logic             w_pop;
    logic             w_last_pop;
    logic             w_accept;
    logic             w_drop;
    logic [127:0]     w_block;
    logic [31:0]      w_word_sel;
    logic [31:0]      w_word;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    // done_d resets high so a done level already present at reset release
    // is not mistaken for a new completion.
    assign w_capture  = done_i & ~r_done_d;
    assign w_pop      = ~w_empty & ready_i;
    assign w_last_pop = w_pop & (r_widx == 2'd3);
    // When full, the slot being freed by a last-word transfer is the one the
    // write pointer already points at, so the new block can take it directly.
    assign w_accept   = w_capture & (~w_full | w_last_pop);
    assign w_drop     = w_capture & w_full & ~w_last_pop;

    // Control state: edge detector, pointers, occupancy, word index, overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_d <= 1'b1;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_widx   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_done_d <= done_i;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_widx <= r_widx + 1'b1;
            end
            if (w_last_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_last_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Block storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_mem[r_wr_ptr] <= text_i;
        end
    end

    assign w_block = r_mem[r_rd_ptr];

    // Select the current 32-bit word of the head block, MSB word first.
    always_comb begin
        w_word_sel = w_block[127:96];
        case (r_widx)
            2'd0:    w_word_sel = w_block[127:96];
            2'd1:    w_word_sel = w_block[95:64];
            2'd2:    w_word_sel = w_block[63:32];
            default: w_word_sel = w_block[31:0];
        endcase
    end

`ifdef AES_OUT_BSWAP_EN
    assign w_word = {w_word_sel[7:0], w_word_sel[15:8],
                     w_word_sel[23:16], w_word_sel[31:24]};
`else
    assign w_word = w_word_sel;
`endif

    assign word_o  = w_empty ? 32'h0 : w_word;
    assign valid_o = ~w_empty;
    assign last_o  = ~w_empty & (r_widx == 2'd3);
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed testbench for aes_out_serializer with a word scoreboard.
// Build with AES_OUT_BSWAP_EN defined to exercise the byte-swapped variant.

module tb_aes_out_serializer;

    localparam int DEPTH = 2;

    logic         clk;
    logic         rst;
    logic         done_i;
    logic [127:0] text_i;
    logic [31:0]  word_o;
    logic         valid_o;
    logic         ready_i;
    logic         last_o;
    logic         full_o;
    logic         empty_o;
    logic         ovf_o;
    logic         clr_ovf_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  m_q[$];
    int           m_widx;
    logic         m_ovf;
    logic         cap_pend;
    logic [127:0] cap_data;

    aes_out_serializer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_i    (done_i),
        .text_i    (text_i),
        .word_o    (word_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .last_o    (last_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .ovf_o     (ovf_o),
        .clr_ovf_i (clr_ovf_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xw(input logic [31:0] w);
`ifdef AES_OUT_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic raise_done(input logic [127:0] data);
        text_i   = data;
        done_i   = 1'b1;
        cap_pend = 1'b1;
        cap_data = data;
    endtask

    // One clock: check head word before the edge, advance the model, then
    // check status flags after the edge.
    task automatic cyc();
        logic pop;
        logic lastp;
        int   blocks;
        if (m_q.size() != 0) begin
            chk32("word", word_o, m_q[0]);
            chk1("last", last_o, (m_widx == 3));
        end else begin
            chk32("word_empty", word_o, 32'h0);
            chk1("last_empty", last_o, 1'b0);
        end
        pop    = (m_q.size() != 0) && ready_i;
        lastp  = pop && (m_widx == 3);
        blocks = (m_q.size() + 3) / 4;
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_widx = 0;
            m_ovf  = 1'b0;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_widx = (m_widx + 1) % 4;
            end
            if (cap_pend && (blocks < DEPTH || lastp)) begin
                m_q.push_back(xw(cap_data[127:96]));
                m_q.push_back(xw(cap_data[95:64]));
                m_q.push_back(xw(cap_data[63:32]));
                m_q.push_back(xw(cap_data[31:0]));
            end
            if (cap_pend && !(blocks < DEPTH || lastp)) begin
                m_ovf = 1'b1;
            end else if (clr_ovf_i) begin
                m_ovf = 1'b0;
            end
        end
        cap_pend = 1'b0;
        chk1("valid", valid_o, (m_q.size() != 0));
        chk1("empty", empty_o, (m_q.size() == 0));
        chk1("full", full_o, (((m_q.size() + 3) / 4) == DEPTH));
        chk1("ovf", ovf_o, m_ovf);
    endtask

    initial begin
        rst       = 1'b1;
        done_i    = 1'b0;
        text_i    = '0;
        ready_i   = 1'b0;
        clr_ovf_i = 1'b0;
        cap_pend  = 1'b0;
        cap_data  = '0;
        m_widx    = 0;
        m_ovf     = 1'b0;

        // Reset
        @(posedge clk);
        #1;
        cyc();
        rst = 1'b0;
        chk32("rst_word", word_o, 32'h0);
        chk1("rst_valid", valid_o, 1'b0);
        chk1("rst_last", last_o, 1'b0);
        chk1("rst_full", full_o, 1'b0);
        chk1("rst_empty", empty_o, 1'b1);
        chk1("rst_ovf", ovf_o, 1'b0);
        cyc();

        // Single block, consumer always ready
        ready_i = 1'b1;
        raise_done(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        cyc();
        done_i = 1'b0;
        chk1("lat_valid", valid_o, 1'b1);
        chk32("lat_word0", word_o, xw(32'h69c4e0d8));
        for (int i = 0; i < 4; i++) cyc();
        chk1("single_drained", empty_o, 1'b1);

        // Level done held 10 cycles, then alternating ready
        ready_i = 1'b0;
        raise_done(128'h00112233445566778899aabbccddeeff);
        cyc();
        for (int i = 0; i < 9; i++) cyc();
        done_i = 1'b0;
        chk1("level_one_block", full_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ready_i = (i % 2 == 0);
            cyc();
        end
        chk1("toggle_drained", empty_o, 1'b1);

        // Overflow: three blocks into two slots with no consumer
        ready_i = 1'b0;
        raise_done(128'h11111111222222223333333344444444);
        cyc();
        done_i = 1'b0;
        cyc();
        raise_done(128'h55555555666666667777777788888888);
        cyc();
        done_i = 1'b0;
        cyc();
        chk1("ovf_full2", full_o, 1'b1);
        chk1("ovf_not_yet", ovf_o, 1'b0);
        raise_done(128'h99999999aaaaaaaabbbbbbbbcccccccc);
        cyc();
        done_i = 1'b0;
        chk1("ovf_set", ovf_o, 1'b1);
        cyc();
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk1("ovf_drained", empty_o, 1'b1);
        chk1("ovf_sticky", ovf_o, 1'b1);
        clr_ovf_i = 1'b1;
        cyc();
        clr_ovf_i = 1'b0;
        chk1("ovf_cleared", ovf_o, 1'b0);

        // Capture coinciding with the last-word transfer while full
        ready_i = 1'b0;
        raise_done(128'hdeadbeef0badf00dcafebabe12345678);
        cyc();
        done_i = 1'b0;
        cyc();
        raise_done(128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0);
        cyc();
        done_i = 1'b0;
        cyc();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk1("sim_at_last", last_o, 1'b1);
        raise_done(128'hfedcba98765432100123456789abcdef);
        cyc();
        done_i = 1'b0;
        chk1("sim_full", full_o, 1'b1);
        chk1("sim_no_ovf", ovf_o, 1'b0);
        for (int i = 0; i < 8; i++) cyc();
        chk1("sim_drained", empty_o, 1'b1);

        // Reset mid-block with done held high through release
        ready_i = 1'b0;
        raise_done(128'h0102030405060708090a0b0c0d0e0f10);
        cyc();
        done_i  = 1'b0;
        ready_i = 1'b1;
        cyc();
        cyc();
        rst     = 1'b1;
        ready_i = 1'b0;
        done_i  = 1'b1;
        cyc();
        chk1("midrst_valid", valid_o, 1'b0);
        chk1("midrst_empty", empty_o, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk1("held_done_no_cap", empty_o, 1'b1);
        done_i = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
